// File: rtl/pep_ks_mb_result_format.sv
// Multi-batch key-switch result formatter: per-batch coefficient FIFOs and
// command holders, round-robin PBS arbitration, packed tagged output words.
module pep_ks_mb_result_format #(
  parameter int BATCH_NB       = 2,
  parameter int LWE_W          = 32,
  parameter int CORR_W         = 8,
  parameter int PID_W          = 6,
  parameter int MAX_COEF_NB    = 1024,
  parameter int OUT_COEF_NB    = 4,
  parameter int RES_FIFO_DEPTH = 8,
  localparam int CNT_W = $clog2(MAX_COEF_NB + 1),
  localparam int BID_W = (BATCH_NB > 1) ? $clog2(BATCH_NB) : 1
) (
  input  logic                                  clk,
  input  logic                                  s_rst,
  input  logic [BATCH_NB-1:0][PID_W-1:0]        cmd_pid,
  input  logic [BATCH_NB-1:0][CNT_W-1:0]        cmd_coef_nb,
  input  logic [BATCH_NB-1:0]                   cmd_vld,
  output logic [BATCH_NB-1:0]                   cmd_rdy,
  input  logic [BATCH_NB-1:0][LWE_W-1:0]        in_lwe,
  input  logic [BATCH_NB-1:0][CORR_W-1:0]       in_corr,
  input  logic [BATCH_NB-1:0]                   in_vld,
  output logic [BATCH_NB-1:0]                   in_rdy,
  input  logic                                  reset_cache,
  output logic [OUT_COEF_NB-1:0][LWE_W-1:0]     out_lwe,
  output logic [OUT_COEF_NB-1:0][CORR_W-1:0]    out_corr,
  output logic [OUT_COEF_NB-1:0]                out_mask,
  output logic [PID_W-1:0]                      out_pid,
  output logic [BID_W-1:0]                      out_batch_id,
  output logic                                  out_last,
  output logic                                  out_vld,
  input  logic                                  out_rdy,
  output logic [BATCH_NB-1:0]                   error_cmd
);

  localparam int AW = $clog2(RES_FIFO_DEPTH);
  localparam int LW = (OUT_COEF_NB > 1) ? $clog2(OUT_COEF_NB) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PACK,
    S_OUT
  } state_e;

  logic [LWE_W-1:0]  mem_lwe  [BATCH_NB][RES_FIFO_DEPTH];
  logic [CORR_W-1:0] mem_corr [BATCH_NB][RES_FIFO_DEPTH];

  logic [BATCH_NB-1:0][AW-1:0]    wptr_q, wptr_d;
  logic [BATCH_NB-1:0][AW-1:0]    rptr_q, rptr_d;
  logic [BATCH_NB-1:0][AW:0]      cnt_q, cnt_d;
  logic [BATCH_NB-1:0]            push, pop;

  logic [BATCH_NB-1:0]            hold_vld_q, hold_vld_d;
  logic [BATCH_NB-1:0][PID_W-1:0] hold_pid_q, hold_pid_d;
  logic [BATCH_NB-1:0][CNT_W-1:0] rem_q, rem_d;
  logic [BATCH_NB-1:0]            err_q, err_d;

  state_e           state_q, state_d;
  logic [BID_W-1:0] cur_q, cur_d;
  logic [BID_W-1:0] rr_q, rr_d;
  logic [LW-1:0]    idx_q, idx_d;

  logic [OUT_COEF_NB-1:0][LWE_W-1:0]  out_lwe_q, out_lwe_d;
  logic [OUT_COEF_NB-1:0][CORR_W-1:0] out_corr_q, out_corr_d;
  logic [OUT_COEF_NB-1:0]             out_mask_q, out_mask_d;
  logic [PID_W-1:0]                   out_pid_q, out_pid_d;
  logic [BID_W-1:0]                   out_bid_q, out_bid_d;
  logic                               out_last_q, out_last_d;
  logic                               out_vld_q, out_vld_d;

  logic             flush;
  logic             found;
  logic [BID_W-1:0] sel;

  assign flush = s_rst | reset_cache;

  always_comb begin
    for (int b = 0; b < BATCH_NB; b++) begin
      in_rdy[b] = (cnt_q[b] != (AW+1)'(RES_FIFO_DEPTH));
      push[b]   = in_vld[b] & in_rdy[b] & ~flush;
    end
  end

  assign cmd_rdy = ~hold_vld_q;

  // Round-robin: first eligible batch at or after rr_q, with wrap.
  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < BATCH_NB; i++) begin
      j = int'(rr_q) + i;
      if (j >= BATCH_NB) j = j - BATCH_NB;
      if (!found && hold_vld_q[j] && cnt_q[j] != '0) begin
        found = 1'b1;
        sel   = BID_W'(j);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    rr_d       = rr_q;
    idx_d      = idx_q;
    hold_vld_d = hold_vld_q;
    hold_pid_d = hold_pid_q;
    rem_d      = rem_q;
    err_d      = '0;
    pop        = '0;
    out_lwe_d  = out_lwe_q;
    out_corr_d = out_corr_q;
    out_mask_d = out_mask_q;
    out_pid_d  = out_pid_q;
    out_bid_d  = out_bid_q;
    out_last_d = out_last_q;
    out_vld_d  = out_vld_q;

    for (int b = 0; b < BATCH_NB; b++) begin
      if (cmd_vld[b] && !hold_vld_q[b]) begin
        if (cmd_coef_nb[b] == '0 ||
            cmd_coef_nb[b] > CNT_W'(MAX_COEF_NB)) begin
          err_d[b] = 1'b1;
        end else begin
          hold_vld_d[b] = 1'b1;
          hold_pid_d[b] = cmd_pid[b];
          rem_d[b]      = cmd_coef_nb[b];
        end
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          cur_d      = sel;
          idx_d      = '0;
          out_pid_d  = hold_pid_q[sel];
          out_bid_d  = sel;
          out_lwe_d  = '0;
          out_corr_d = '0;
          out_mask_d = '0;
          out_last_d = 1'b0;
          state_d    = S_PACK;
        end
      end
      S_PACK: begin
        if (cnt_q[cur_q] != '0) begin
          pop[cur_q]        = 1'b1;
          out_lwe_d[idx_q]  = mem_lwe[cur_q][rptr_q[cur_q]];
          out_corr_d[idx_q] = mem_corr[cur_q][rptr_q[cur_q]];
          out_mask_d[idx_q] = 1'b1;
          rem_d[cur_q]      = rem_q[cur_q] - CNT_W'(1);
          idx_d             = idx_q + LW'(1);
          if (idx_q == LW'(OUT_COEF_NB - 1) ||
              rem_q[cur_q] == CNT_W'(1)) begin
            out_vld_d  = 1'b1;
            out_last_d = (rem_q[cur_q] == CNT_W'(1));
            state_d    = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (out_rdy) begin
          out_vld_d = 1'b0;
          if (out_last_q) begin
            hold_vld_d[cur_q] = 1'b0;
            rr_d    = (cur_q == BID_W'(BATCH_NB - 1)) ? '0
                                                      : cur_q + BID_W'(1);
            state_d = S_IDLE;
          end else begin
            idx_d      = '0;
            out_lwe_d  = '0;
            out_corr_d = '0;
            out_mask_d = '0;
            state_d    = S_PACK;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    for (int b = 0; b < BATCH_NB; b++) begin
      wptr_d[b] = wptr_q[b] + AW'(push[b]);
      rptr_d[b] = rptr_q[b] + AW'(pop[b]);
      cnt_d[b]  = cnt_q[b] + (AW+1)'(push[b]) - (AW+1)'(pop[b]);
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < BATCH_NB; b++) begin
      if (push[b]) begin
        mem_lwe[b][wptr_q[b]]  <= in_lwe[b];
        mem_corr[b][wptr_q[b]] <= in_corr[b];
      end
    end
  end

  // Flush and reset share one path: everything returns to the empty state.
  always_ff @(posedge clk) begin
    if (flush) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      hold_vld_q <= '0;
      hold_pid_q <= '0;
      rem_q      <= '0;
      err_q      <= '0;
      state_q    <= S_IDLE;
      cur_q      <= '0;
      rr_q       <= '0;
      idx_q      <= '0;
      out_lwe_q  <= '0;
      out_corr_q <= '0;
      out_mask_q <= '0;
      out_pid_q  <= '0;
      out_bid_q  <= '0;
      out_last_q <= 1'b0;
      out_vld_q  <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      hold_vld_q <= hold_vld_d;
      hold_pid_q <= hold_pid_d;
      rem_q      <= rem_d;
      err_q      <= err_d;
      state_q    <= state_d;
      cur_q      <= cur_d;
      rr_q       <= rr_d;
      idx_q      <= idx_d;
      out_lwe_q  <= out_lwe_d;
      out_corr_q <= out_corr_d;
      out_mask_q <= out_mask_d;
      out_pid_q  <= out_pid_d;
      out_bid_q  <= out_bid_d;
      out_last_q <= out_last_d;
      out_vld_q  <= out_vld_d;
    end
  end

  assign out_lwe      = out_lwe_q;
  assign out_corr     = out_corr_q;
  assign out_mask     = out_mask_q;
  assign out_pid      = out_pid_q;
  assign out_batch_id = out_bid_q;
  assign out_last     = out_last_q;
  assign out_vld      = out_vld_q;
  assign error_cmd    = err_q;

endmodule

// File: tb/tb_pep_ks_mb_result_format.sv
// Directed bench for pep_ks_mb_result_format with default parameters.
module tb_pep_ks_mb_result_format;

  logic             clk = 1'b0;
  logic             s_rst;
  logic [1:0][5:0]  cmd_pid;
  logic [1:0][10:0] cmd_coef_nb;
  logic [1:0]       cmd_vld;
  logic [1:0]       cmd_rdy;
  logic [1:0][31:0] in_lwe;
  logic [1:0][7:0]  in_corr;
  logic [1:0]       in_vld;
  logic [1:0]       in_rdy;
  logic             reset_cache;
  logic [3:0][31:0] out_lwe;
  logic [3:0][7:0]  out_corr;
  logic [3:0]       out_mask;
  logic [5:0]       out_pid;
  logic [0:0]       out_batch_id;
  logic             out_last;
  logic             out_vld;
  logic             out_rdy;
  logic [1:0]       error_cmd;

  int checks = 0;
  int errors = 0;

  pep_ks_mb_result_format dut (
    .clk(clk), .s_rst(s_rst),
    .cmd_pid(cmd_pid), .cmd_coef_nb(cmd_coef_nb),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .in_lwe(in_lwe), .in_corr(in_corr),
    .in_vld(in_vld), .in_rdy(in_rdy),
    .reset_cache(reset_cache),
    .out_lwe(out_lwe), .out_corr(out_corr),
    .out_mask(out_mask), .out_pid(out_pid),
    .out_batch_id(out_batch_id), .out_last(out_last),
    .out_vld(out_vld), .out_rdy(out_rdy),
    .error_cmd(error_cmd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_vld(input string tag);
    for (int k = 0; k < 60 && out_vld !== 1'b1; k++) tick();
    chk(tag, out_vld, 1'b1);
  endtask

  task automatic accept();
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
  endtask

  task automatic cmd(input int b, input int pid, input int nb);
    cmd_vld[b]     = 1'b1;
    cmd_pid[b]     = 6'(pid);
    cmd_coef_nb[b] = 11'(nb);
    tick();
    cmd_vld = '0;
  endtask

  task automatic push1(input int b, input int v);
    in_vld[b]  = 1'b1;
    in_lwe[b]  = 32'(v);
    in_corr[b] = 8'(v + 16);
    tick();
    in_vld = '0;
  endtask

  task automatic check_word(input string tag, input logic [127:0] lwe,
                            input logic [3:0] mask, input logic last,
                            input logic [5:0] pid, input logic bid);
    chk({tag, "_lwe"}, out_lwe, lwe);
    chk({tag, "_mask"}, out_mask, mask);
    chk({tag, "_last"}, out_last, last);
    chk({tag, "_pid"}, out_pid, pid);
    chk({tag, "_bid"}, out_batch_id, bid);
  endtask

  initial begin
    s_rst = 1'b1; reset_cache = 1'b0;
    cmd_vld = '0; cmd_pid = '0; cmd_coef_nb = '0;
    in_vld = '0; in_lwe = '0; in_corr = '0; out_rdy = 1'b0;
    tick(); tick();
    s_rst = 1'b0;
    tick();
    chk("rst_vld", out_vld, 1'b0);
    chk("rst_last", out_last, 1'b0);
    chk("rst_mask", out_mask, 4'b0);
    chk("rst_lwe", out_lwe, 128'b0);
    chk("rst_err", error_cmd, 2'b00);
    chk("rst_cmd_rdy", cmd_rdy, 2'b11);
    chk("rst_in_rdy", in_rdy, 2'b11);

    // Single PBS of 6 coefficients split into two words
    cmd(0, 5, 6);
    for (int i = 1; i <= 6; i++) push1(0, i);
    wait_vld("w0_vld");
    check_word("w0", {32'd4, 32'd3, 32'd2, 32'd1}, 4'b1111, 1'b0,
               6'd5, 1'b0);
    chk("w0_corr", out_corr, {8'd20, 8'd19, 8'd18, 8'd17});
    accept();
    wait_vld("w1_vld");
    check_word("w1", {32'd0, 32'd0, 32'd6, 32'd5}, 4'b0011, 1'b1,
               6'd5, 1'b0);
    chk("w1_corr", out_corr, {8'd0, 8'd0, 8'd22, 8'd21});
    accept();
    chk("w1_done_vld", out_vld, 1'b0);
    chk("w1_cmd_rdy", cmd_rdy, 2'b11);

    // Flush to clear rr_ptr, then fill both FIFOs to capacity
    reset_cache = 1'b1; tick(); reset_cache = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_vld = 2'b11;
      in_lwe[0] = 32'(100 + i); in_corr[0] = 8'(i);
      in_lwe[1] = 32'(200 + i); in_corr[1] = 8'(i);
      tick();
    end
    in_vld = '0;
    chk("full_in_rdy", in_rdy, 2'b00);
    in_vld = 2'b11; in_lwe[0] = 32'd999; in_lwe[1] = 32'd999;
    tick();
    in_vld = '0;
    chk("full_no_out", out_vld, 1'b0);

    cmd_vld = 2'b11;
    cmd_pid[0] = 6'd10; cmd_coef_nb[0] = 11'd4;
    cmd_pid[1] = 6'd11; cmd_coef_nb[1] = 11'd4;
    tick();
    cmd_vld = '0;

    wait_vld("rr0_vld");
    check_word("rr0", {32'd103, 32'd102, 32'd101, 32'd100}, 4'b1111,
               1'b1, 6'd10, 1'b0);
    repeat (10) tick();
    chk("bp_vld", out_vld, 1'b1);
    check_word("bp", {32'd103, 32'd102, 32'd101, 32'd100}, 4'b1111,
               1'b1, 6'd10, 1'b0);
    accept();
    cmd(0, 12, 4);
    wait_vld("rr1_vld");
    check_word("rr1", {32'd203, 32'd202, 32'd201, 32'd200}, 4'b1111,
               1'b1, 6'd11, 1'b1);
    accept();
    cmd(1, 13, 4);
    wait_vld("rr2_vld");
    check_word("rr2", {32'd107, 32'd106, 32'd105, 32'd104}, 4'b1111,
               1'b1, 6'd12, 1'b0);
    accept();
    wait_vld("rr3_vld");
    check_word("rr3", {32'd207, 32'd206, 32'd205, 32'd204}, 4'b1111,
               1'b1, 6'd13, 1'b1);
    accept();
    tick();
    chk("rr_empty_in_rdy", in_rdy, 2'b11);
    chk("rr_cmd_rdy", cmd_rdy, 2'b11);
    chk("rr_idle_vld", out_vld, 1'b0);

    // Illegal commands: zero count and count above maximum
    cmd(1, 7, 0);
    chk("ill0_err", error_cmd, 2'b10);
    chk("ill0_cmd_rdy", cmd_rdy, 2'b11);
    tick();
    chk("ill0_err_clr", error_cmd, 2'b00);
    cmd(0, 7, 1025);
    chk("ill1_err", error_cmd, 2'b01);
    chk("ill1_cmd_rdy", cmd_rdy, 2'b11);
    push1(1, 55);
    repeat (4) tick();
    chk("ill_no_out", out_vld, 1'b0);
    chk("ill_err_end", error_cmd, 2'b00);
    cmd(0, 8, 1024);
    chk("max_ok_err", error_cmd, 2'b00);
    chk("max_ok_cmd_rdy", cmd_rdy, 2'b10);

    // Flush mid-PACK after two pops
    reset_cache = 1'b1; tick(); reset_cache = 1'b0;
    chk("fl0_cmd_rdy", cmd_rdy, 2'b11);
    cmd(0, 3, 6);
    for (int i = 1; i <= 4; i++) push1(0, i);
    reset_cache = 1'b1;
    in_vld[1] = 1'b1; in_lwe[1] = 32'd66;
    tick();
    reset_cache = 1'b0; in_vld = '0;
    chk("fl_vld", out_vld, 1'b0);
    chk("fl_mask", out_mask, 4'b0);
    chk("fl_cmd_rdy", cmd_rdy, 2'b11);
    chk("fl_in_rdy", in_rdy, 2'b11);
    cmd(0, 9, 1);
    repeat (3) tick();
    chk("fl_empty_no_out", out_vld, 1'b0);
    push1(0, 77);
    wait_vld("fl_w_vld");
    check_word("fl_w", {32'd0, 32'd0, 32'd0, 32'd77}, 4'b0001, 1'b1,
               6'd9, 1'b0);
    accept();

    // Reset during OUT with a simultaneous handshake
    cmd(1, 21, 2);
    push1(1, 31);
    push1(1, 32);
    wait_vld("sr_pre_vld");
    check_word("sr_pre", {32'd0, 32'd0, 32'd32, 32'd31}, 4'b0011, 1'b1,
               6'd21, 1'b1);
    s_rst = 1'b1; out_rdy = 1'b1;
    tick();
    s_rst = 1'b0; out_rdy = 1'b0;
    chk("sr_vld", out_vld, 1'b0);
    check_word("sr", 128'b0, 4'b0, 1'b0, 6'd0, 1'b0);
    chk("sr_corr", out_corr, 32'b0);
    chk("sr_cmd_rdy", cmd_rdy, 2'b11);
    chk("sr_in_rdy", in_rdy, 2'b11);
    repeat (3) tick();
    chk("sr_stay_idle", out_vld, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pep_ks_mb_result_format.md
# pep_ks_mb_result_format

Multi-batch result formatter for the key-switch output path. It generalises the single-batch result stage to `BATCH_NB` independent batch channels and packs `OUT_COEF_NB` LWE coefficients per output word. Per-batch LWE coefficient streams and per-PBS commands come in from the key-switch output process. Complete PBS results go out, packed and tagged with batch id and pid, to the sequencer side. It buffers each batch, arbitrates round-robin per PBS, and supports cache flush.

## Interface
Parameters:
- `BATCH_NB`, 2: number of batch channels (≥1).
- `LWE_W`, 32: LWE coefficient width.
- `CORR_W`, 8: correction field width per coefficient.
- `PID_W`, 6: PBS id width.
- `MAX_COEF_NB`, 1024: maximum coefficients per PBS command.
- `OUT_COEF_NB`, 4: coefficient lanes per output word (≥1).
- `RES_FIFO_DEPTH`, 8: per-batch coefficient FIFO depth (power of 2, ≥2).
- Derived: `CNT_W = $clog2(MAX_COEF_NB+1)`, `BID_W = max(1,$clog2(BATCH_NB))`.

Ports:
- `clk`, in, 1: the block's single clock.
- `s_rst`, in, 1: reset, synchronous, active-high.
- `cmd_pid`, in, `[BATCH_NB][PID_W]`: pid of the next PBS for each batch.
- `cmd_coef_nb`, in, `[BATCH_NB][CNT_W]`: coefficient count for that PBS.
- `cmd_vld` / `cmd_rdy`, in / out, `[BATCH_NB]`: command handshake.
- `in_lwe`, in, `[BATCH_NB][LWE_W]`: coefficient.
- `in_corr`, in, `[BATCH_NB][CORR_W]`: coefficient correction.
- `in_vld` / `in_rdy`, in / out, `[BATCH_NB]`: coefficient handshake.
- `reset_cache`, in, 1: flush pulse.
- `out_lwe`, out, `[OUT_COEF_NB][LWE_W]`: packed coefficients, lane 0 = oldest.
- `out_corr`, out, `[OUT_COEF_NB][CORR_W]`: packed corrections.
- `out_mask`, out, `[OUT_COEF_NB]`: lane-valid mask.
- `out_pid`, out, `PID_W`: pid tag.
- `out_batch_id`, out, `BID_W`: batch tag.
- `out_last`, out, 1: last word of the PBS.
- `out_vld` / `out_rdy`, out / in, 1: output handshake.
- `error_cmd`, out, `[BATCH_NB]`: one-cycle pulse on illegal command.

## Operation
- Coefficient FIFO per batch, depth `RES_FIFO_DEPTH`.
  - `in_rdy[b]` = FIFO b not full.
  - Push on `in_vld & in_rdy`.
- One-entry command holder per batch.
  - `cmd_rdy[b]` = holder b empty.
  - Accepting a command with `cmd_coef_nb` = 0 or > `MAX_COEF_NB` drops it and pulses `error_cmd[b]` on the next cycle.
  - A legal command loads the holder; its `remaining` counter is set to `cmd_coef_nb`.
- FSM states:
  - **IDLE**: eligible batch = holder full and FIFO non-empty. Pick the first eligible batch at or after `rr_ptr`, searching upward with wrap-around. Latch it as `cur`, clear the lane index, go to PACK. If none is eligible, stay in IDLE.
  - **PACK**: if FIFO `cur` is non-empty, pop one coefficient into lane `idx`, set `out_mask[idx]`, decrement `remaining`, increment `idx`.
    - If the pop fills lane `OUT_COEF_NB-1`, or `remaining` becomes 0, go to OUT.
    - If FIFO `cur` is empty, wait in PACK. There is no interleave with other batches mid-PBS.
  - **OUT**: `out_vld`=1. On `out_rdy`:
    - If `out_last` (`remaining`==0): free holder `cur`, set `rr_ptr` = `cur`+1 (mod `BATCH_NB`), go to IDLE.
    - Otherwise: clear the mask and `idx`, go to PACK.
- Unused lanes hold zero data and a 0 mask bit.
- `out_pid`/`out_batch_id` come from the holder `cur`; they are stable across all words of a PBS.
- `reset_cache` (and `s_rst`):
  - empties all FIFOs and holders;
  - sets the FSM to IDLE, `rr_ptr` to 0 and outputs to 0 on the next cycle;
  - has priority over a simultaneous push, command or output handshake, all of which are discarded.
- A command may be accepted for batch b while other batches are packing. A new command for `cur` is accepted in the cycle after its holder frees.

## Timing
- Reset values: `out_vld`=0, `out_last`=0, `out_mask`=0, `out_lwe`/`out_corr`/`out_pid`/`out_batch_id`=0, `error_cmd`=0. After `s_rst` deasserts, `cmd_rdy` and `in_rdy` are all 1.
- All outputs are registered.
- Latency:
  - A coefficient pushed in cycle t into an empty FIFO is poppable at t+1.
  - IDLE selection takes 1 cycle. A word of k coefficients with no stalls needs k PACK cycles and is presented in OUT from the cycle after the last pop.
  - With FIFO b pre-filled, its `OUT_COEF_NB`=4 first word is valid 5 cycles after IDLE sees batch b eligible.
- Throughput: one word per `OUT_COEF_NB`+1 cycles, plus 1 IDLE cycle per PBS.
- Held-data rule: while `out_vld`=1 and `out_rdy`=0, all out_* fields hold stable.
- FIFO boundaries:
  - A push and a pop in the same cycle at full is allowed only if `in_rdy` was 1, so a full FIFO never overflows.
  - A pop on empty never occurs.

## Test plan
- Single PBS split across words: `BATCH_NB`=2, `OUT_COEF_NB`=4, batch 0 cmd pid=5 coef_nb=6, coefficients 1..6 → two words: [1,2,3,4] mask 1111 last=0, then [5,6,0,0] mask 0011 last=1, pid=5, batch_id=0.
- Round-robin: both batches hold commands (coef_nb=4) and full FIFOs, `rr_ptr`=0 → order is batch 0, 1, 0, 1. There is no interleave within a PBS.
- Backpressure: `out_rdy`=0 for 10 cycles during OUT → fields stable. Batch FIFO reaches 8 entries, then `in_rdy`=0, and no coefficient is lost.
- Illegal command: coef_nb=0 on batch 1 → `error_cmd[1]` pulses once, `cmd_rdy[1]` stays 1, no output.
- Flush mid-PACK: `reset_cache` after 2 pops → next cycle `out_vld`=0, all FIFOs empty, `cmd_rdy`=all 1. A fresh cmd coef_nb=1 then yields one word, mask 0001, last=1.
- `s_rst` during OUT with `out_rdy`=1 in the same cycle → the handshake is ignored and all outputs are at reset values next cycle.
